// File: rtl/inst_arb_pkg.sv
// rtl/inst_arb_pkg.sv - shared types and defaults for the instruction ROM arbiter
package inst_arb_pkg;

  localparam int ARB_ADDR_W   = 32;
  localparam int ARB_DATA_W   = 32;
  localparam int DEF_MAX_WAIT = 4;

  typedef enum logic {
    PORT_IF  = 1'b0,
    PORT_DBG = 1'b1
  } port_e;

  typedef struct packed {
    logic                  valid;
    logic [ARB_ADDR_W-1:0] addr;
  } arb_req_t;

  typedef struct packed {
    logic                  valid;
    logic [ARB_DATA_W-1:0] inst;
    logic                  err;
  } arb_rsp_t;

endpackage

// File: rtl/defines.vh
// rtl/defines.vh - shared chip-enable and zero-word macros for the ROM arbiter
`ifndef INST_ARB_DEFINES_VH
`define INST_ARB_DEFINES_VH
`define CENABLE   1'b1
`define CDISABLE  1'b0
`define ZERO_WORD 32'h0000_0000
`endif

// File: rtl/rsp_slot.sv
// rtl/rsp_slot.sv - one-entry registered response slot with load/drain and backpressure
module rsp_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_inst,
  input  logic              load_err,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_inst,
  output logic              rsp_err,
  output logic              slot_free
);

  // A draining slot can accept a new load in the same cycle.
  assign slot_free = !rsp_valid || rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_inst  <= '0;
      rsp_err   <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_inst  <= load_inst;
      rsp_err   <= load_err;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_rom_arbiter.sv
// rtl/inst_rom_arbiter.sv - IF/debug arbiter for a shared combinational instruction ROM
`include "defines.vh"

module inst_rom_arbiter
  import inst_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int WAIT_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rsp_inst,
  output logic              if_rsp_err,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  output logic              dbg_rsp_valid,
  input  logic              dbg_rsp_ready,
  output logic [DATA_W-1:0] dbg_rsp_inst,
  output logic              dbg_rsp_err,
  output logic              rom_cen,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  arb_req_t [1:0]    req;
  logic [1:0]        slot_free;
  logic [1:0]        elig;
  logic [1:0]        fire;
  logic              gnt_any;
  port_e             gnt_port;
  logic [ADDR_W-1:0] sel_addr;
  logic              aligned;
  logic [DATA_W-1:0] load_inst;
  logic [WAIT_W-1:0] wait_cnt;

  assign req[PORT_IF]  = '{valid: if_req_valid,  addr: ARB_ADDR_W'(if_req_addr)};
  assign req[PORT_DBG] = '{valid: dbg_req_valid, addr: ARB_ADDR_W'(dbg_req_addr)};

  assign elig[PORT_IF]  = req[PORT_IF].valid  && slot_free[PORT_IF];
  assign elig[PORT_DBG] = req[PORT_DBG].valid && slot_free[PORT_DBG];

  // IF wins ties unless debug has already lost MAX_WAIT cycles in a row.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_port = PORT_IF;
    if (elig[PORT_DBG] && (!elig[PORT_IF] || wait_cnt >= WAIT_W'(MAX_WAIT))) begin
      gnt_any  = 1'b1;
      gnt_port = PORT_DBG;
    end else if (elig[PORT_IF]) begin
      gnt_any  = 1'b1;
      gnt_port = PORT_IF;
    end
  end

  assign fire[PORT_IF]  = gnt_any && rst_n && (gnt_port == PORT_IF);
  assign fire[PORT_DBG] = gnt_any && rst_n && (gnt_port == PORT_DBG);
  assign if_req_ready   = fire[PORT_IF];
  assign dbg_req_ready  = fire[PORT_DBG];

  assign sel_addr  = (gnt_any && rst_n) ? ADDR_W'(req[gnt_port].addr) : '0;
  assign aligned   = (sel_addr[1:0] == 2'b00);
  assign rom_addr  = sel_addr;
  assign rom_cen   = (gnt_any && rst_n && aligned) ? `CENABLE : `CDISABLE;
  assign load_inst = aligned ? rom_inst : DATA_W'(`ZERO_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!dbg_req_valid || fire[PORT_DBG]) begin
      wait_cnt <= '0;
    end else if (elig[PORT_DBG] && wait_cnt != WAIT_W'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  rsp_slot #(.DATA_W(DATA_W)) u_if_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (fire[PORT_IF]),
    .load_inst (load_inst),
    .load_err  (!aligned),
    .rsp_ready (if_rsp_ready),
    .rsp_valid (if_rsp_valid),
    .rsp_inst  (if_rsp_inst),
    .rsp_err   (if_rsp_err),
    .slot_free (slot_free[PORT_IF])
  );

  rsp_slot #(.DATA_W(DATA_W)) u_dbg_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (fire[PORT_DBG]),
    .load_inst (load_inst),
    .load_err  (!aligned),
    .rsp_ready (dbg_rsp_ready),
    .rsp_valid (dbg_rsp_valid),
    .rsp_inst  (dbg_rsp_inst),
    .rsp_err   (dbg_rsp_err),
    .slot_free (slot_free[PORT_DBG])
  );

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// tb/tb_inst_rom_arbiter.sv - self-checking bench for inst_rom_arbiter
module tb_inst_rom_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
  logic [31:0] if_req_addr, if_rsp_inst;
  logic        dbg_req_valid, dbg_req_ready, dbg_rsp_valid, dbg_rsp_ready, dbg_rsp_err;
  logic [31:0] dbg_req_addr, dbg_rsp_inst;
  logic        rom_cen;
  logic [31:0] rom_addr, rom_inst;

  int tests = 0;
  int fails = 0;
  int dbg_grants = 0;

  // Reference state: what each response slot must hold, and debug's losing streak.
  logic        m_valid [2];
  logic [31:0] m_inst  [2];
  logic        m_err   [2];
  int          m_lost;

  always #5 clk = ~clk;

  inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW), .WAIT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_inst(if_rsp_inst),
    .if_rsp_err(if_rsp_err),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_addr(dbg_req_addr),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready), .dbg_rsp_inst(dbg_rsp_inst),
    .dbg_rsp_err(dbg_rsp_err),
    .rom_cen(rom_cen), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'h2401_0005;
    return {a[15:0] ^ 16'hA5A5, ~a[15:0]};
  endfunction

  always_comb rom_inst = rom_fn(rom_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < 2; p++) begin
      m_valid[p] = 1'b0;
      m_inst[p]  = 32'h0;
      m_err[p]   = 1'b0;
    end
    m_lost = 0;
  endtask

  task automatic check_rsp(input string tag);
    check({tag, ":if_rsp_valid"},  if_rsp_valid,  m_valid[0]);
    check({tag, ":if_rsp_inst"},   if_rsp_inst,   m_inst[0]);
    check({tag, ":if_rsp_err"},    if_rsp_err,    m_err[0]);
    check({tag, ":dbg_rsp_valid"}, dbg_rsp_valid, m_valid[1]);
    check({tag, ":dbg_rsp_inst"},  dbg_rsp_inst,  m_inst[1]);
    check({tag, ":dbg_rsp_err"},   dbg_rsp_err,   m_err[1]);
  endtask

  // One clock of stimulus: drive, check combinational grant/ROM outputs, then responses.
  task automatic cyc(input logic ifv, input logic [31:0] ifa, input logic ifr,
                     input logic dv, input logic [31:0] da, input logic dr);
    logic [1:0]  v, rr, el, g;
    logic [31:0] a [2];
    logic [31:0] ga;
    @(negedge clk);
    if_req_valid = ifv;  if_req_addr = ifa;  if_rsp_ready = ifr;
    dbg_req_valid = dv;  dbg_req_addr = da;  dbg_rsp_ready = dr;
    #1;
    v = {dv, ifv};  rr = {dr, ifr};  a[0] = ifa;  a[1] = da;
    for (int p = 0; p < 2; p++) el[p] = v[p] && (!m_valid[p] || rr[p]);
    g[1] = el[1] && (!el[0] || m_lost >= MAXW);
    g[0] = el[0] && !g[1];
    ga = g[1] ? da : (g[0] ? ifa : 32'h0);
    check("if_req_ready",  if_req_ready,  g[0]);
    check("dbg_req_ready", dbg_req_ready, g[1]);
    check("rom_addr", rom_addr, ga);
    check("rom_cen",  rom_cen,  (g != 2'b00) && (ga[1:0] == 2'b00));
    if (dbg_req_ready) dbg_grants++;
    @(posedge clk);
    for (int p = 0; p < 2; p++) begin
      if (g[p]) begin
        m_valid[p] = 1'b1;
        m_err[p]   = (a[p][1:0] != 2'b00);
        m_inst[p]  = m_err[p] ? 32'h0 : rom_fn(a[p]);
      end else if (m_valid[p] && rr[p]) begin
        m_valid[p] = 1'b0;
      end
    end
    if (!dv || g[1]) m_lost = 0;
    else if (el[1] && m_lost < MAXW) m_lost++;
    #1;
    check_rsp("rsp");
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, ":if_req_ready"},  if_req_ready,  1'b0);
    check({tag, ":dbg_req_ready"}, dbg_req_ready, 1'b0);
    check({tag, ":rom_cen"},       rom_cen,       1'b0);
    check_rsp(tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    model_clear();
    rst_n = 1'b0;
    if_req_valid = 1'b1;  if_req_addr = 32'h100;  if_rsp_ready = 1'b1;
    dbg_req_valid = 1'b1; dbg_req_addr = 32'h200; dbg_rsp_ready = 1'b1;
    #1;
    check_in_reset("reset");
    @(posedge clk); #1;
    check_in_reset("reset_edge");
    @(negedge clk); rst_n = 1'b1;

    // Single IF fetch, then drain with nothing behind it.
    cyc(1, 32'h100, 1, 0, 32'h0, 1);
    cyc(0, 32'h0,   1, 0, 32'h0, 1);

    // Back-to-back IF stream.
    cyc(1, 32'h100, 1, 0, 32'h0, 1);
    cyc(1, 32'h104, 1, 0, 32'h0, 1);
    cyc(1, 32'h108, 1, 0, 32'h0, 1);
    cyc(0, 32'h0,   1, 0, 32'h0, 1);

    // Both ports hammering: 4:1 starvation guard.
    dbg_grants = 0;
    for (int i = 0; i < 10; i++) cyc(1, 32'h300 + 32'(4 * i), 1, 1, 32'h400 + 32'(4 * i), 1);
    check("dbg_grants_4to1", 32'(dbg_grants), 32'd2);
    cyc(0, 32'h0, 1, 0, 32'h0, 1);

    // Misaligned debug address.
    cyc(0, 32'h0, 1, 1, 32'h102, 1);
    cyc(0, 32'h0, 1, 0, 32'h0,   1);

    // IF backpressure while debug keeps being served, then drain-and-refill.
    cyc(1, 32'h500, 0, 0, 32'h0,   1);
    for (int i = 0; i < 3; i++) cyc(1, 32'h504, 0, 1, 32'h600 + 32'(4 * i), 1);
    cyc(1, 32'h504, 1, 0, 32'h0, 1);
    cyc(0, 32'h0,   1, 0, 32'h0, 1);

    // Reset the cycle after an IF fire, with another fetch in flight.
    cyc(1, 32'h100, 1, 0, 32'h0, 1);
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h104; dbg_req_valid = 1'b1;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_in_reset("midreset");
    @(posedge clk); #1;
    check_in_reset("midreset_edge");
    @(negedge clk); rst_n = 1'b1;
    cyc(1, 32'h100, 1, 0, 32'h0, 1);
    cyc(0, 32'h0,   1, 0, 32'h0, 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      ra = {20'h0, 10'($urandom_range(0, 1023)), ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      rb = {20'h1, 10'($urandom_range(0, 1023)), ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      cyc($urandom_range(0, 3) != 0, ra, $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) != 0, rb, $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_rom_arbiter.md
Name: inst_rom_arbiter

Overview:
- Shares the single combinational-read instruction ROM between two requesters.
- Port 0 is the IF stage; port 1 is the debug/trace reader.
- Each port uses a valid/ready request channel and a one-entry registered response slot. Response latency is 1 cycle.
- Arbitration is fixed priority to IF, with a starvation guard that forces a debug grant after MAX_WAIT lost cycles.

Parameters:
- ADDR_W, 32, request/ROM address width
- DATA_W, 32, instruction width
- MAX_WAIT, 4, consecutive lost cycles after which DBG beats IF
- WAIT_W, 3, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  asynchronous active-low reset
- IF_REQ_VALID  in  1  IF fetch request
- IF_REQ_READY  out  1  IF request accepted this cycle when high with valid
- IF_REQ_ADDR  in  ADDR_W  IF byte address
- IF_RSP_VALID  out  1  IF response slot full
- IF_RSP_READY  in  1  IF consumes response
- IF_RSP_INST  out  DATA_W  IF instruction
- IF_RSP_ERR  out  1  IF misaligned-address flag
- DBG_REQ_VALID / DBG_REQ_READY / DBG_REQ_ADDR  same as IF_*, port 1
- DBG_RSP_VALID / DBG_RSP_READY / DBG_RSP_INST / DBG_RSP_ERR  same as IF_*, port 1
- ROM_CEN  out  1  ROM chip enable: `CENABLE on an aligned grant, else `CDISABLE
- ROM_ADDR  out  ADDR_W  granted address; zero when no grant
- ROM_INST  in  DATA_W  combinational ROM data for ROM_ADDR

Behaviour:
- Reset (RSTN low, asynchronous):
  - Both RSP_VALID=0, RSP_INST=0, RSP_ERR=0, wait_cnt=0.
  - Both REQ_READY=0 and ROM_CEN=`CDISABLE while RSTN is low.
- slot_free[p] = !RSP_VALID[p] || RSP_READY[p]. Same-cycle drain-and-refill is allowed.
- elig[p] = REQ_VALID[p] && slot_free[p].
- Grant (combinational, at most one port per cycle):
  - Only one port eligible: that port is granted.
  - Both eligible: DBG is granted if wait_cnt >= MAX_WAIT, else IF.
  - REQ_READY[p] = grant[p] && RSTN.
- Fire on a port = REQ_VALID && REQ_READY. On fire at cycle t:
  - ROM_ADDR = granted address.
  - ROM_CEN = `CENABLE only if ADDR[1:0]==0.
- Edge ending cycle t:
  - Aligned request: RSP_INST[p] <= ROM_INST, RSP_ERR[p] <= 0, RSP_VALID[p] <= 1.
  - Misaligned request: RSP_INST[p] <= 0, RSP_ERR[p] <= 1, RSP_VALID[p] <= 1. The ROM is not enabled.
  - Response therefore visible at t+1 (latency 1).
- A response is cleared when RSP_VALID && RSP_READY and the same port does not fire in that cycle. RSP_INST/RSP_ERR hold their values after clear.
- Response registers hold stable while RSP_VALID && !RSP_READY. In that state the port's REQ_READY=0 (backpressure).
- wait_cnt:
  - Increments, saturating at MAX_WAIT, when DBG is eligible but not granted.
  - Clears when DBG fires or DBG_REQ_VALID=0.
  - Holds when DBG is valid but its slot is full.
- Ports are independent: a full IF slot never blocks DBG, and vice versa.
- No grant: ROM_CEN=`CDISABLE, ROM_ADDR=0.
- Reset mid-operation: pending responses are discarded and no response is produced for an in-flight fire.
- Address high bits beyond ROM depth are passed through unchanged; ROM aliasing is the ROM's behaviour.

Decomposition:
- Shared package inst_arb_pkg holds:
  - port index enum {PORT_IF=0, PORT_DBG=1}
  - typedef arb_req_t {valid, addr}
  - typedef arb_rsp_t {valid, inst, err}
  - the default MAX_WAIT constant
- CENABLE/CDISABLE/ZERO_WORD come from defines.vh.
- Sub-module rsp_slot (one-entry response register with load/drain logic and backpressure output), instantiated once per port.
- The top level holds grant logic, wait counter and ROM muxing.

Test Plan:
- IF only, ADDR=0x100, ROM_INST=0x24010005, RSP_READY=1 -> ROM_CEN=`CENABLE and ROM_ADDR=0x100 in cycle t; IF_RSP_VALID=1 and IF_RSP_INST=0x24010005 at t+1, then IF_RSP_VALID=0 at t+2 unless refired.
- Back-to-back IF fetches 0x100, 0x104, 0x108 with RSP_READY=1 -> one response per cycle, no bubbles, in order.
- Both ports valid every cycle, MAX_WAIT=4, all RSP_READY=1 -> IF granted 4 cycles, DBG on the 5th, wait_cnt back to 0; pattern repeats (4:1).
- DBG ADDR=0x102 -> ROM_CEN=`CDISABLE; next cycle DBG_RSP_VALID=1, DBG_RSP_ERR=1, DBG_RSP_INST=0.
- IF_RSP_READY=0 with IF response held -> IF_REQ_READY=0 and IF_RSP_INST stable; DBG still served. Raising IF_RSP_READY with IF_REQ_VALID=1 drains and refills in the same cycle.
- RSTN asserted the cycle after an IF fire -> all RSP_VALID=0 immediately, REQ_READY=0; after release, first fetch behaves as the first scenario.
